// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: round constants, IV, rotate and round-function
// helpers, and the compression FSM state type.
package sha1_pkg;

  localparam logic [31:0]  K_00_19 = 32'h5A827999;
  localparam logic [31:0]  K_20_39 = 32'h6ED9EBA1;
  localparam logic [31:0]  K_40_59 = 32'h8F1BBCDC;
  localparam logic [31:0]  K_60_79 = 32'hCA62C1D6;
  localparam logic [159:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [6:0]   LAST_T  = 7'd79;

  typedef enum logic {
    ST_IDLE,
    ST_ROUND
  } state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] k_t(input logic [6:0] t);
    if (t < 7'd20)      return K_00_19;
    else if (t < 7'd40) return K_20_39;
    else if (t < 7'd60) return K_40_59;
    else                return K_60_79;
  endfunction

  function automatic logic [31:0] f_t(input logic [6:0] t, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: working variables a..e plus W_t and the
// round index t produce the next a..e.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [6:0]  t,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  logic [31:0] temp;

  assign temp = rotl(a_i, 5) + f_t(t, b_i, c_i, d_i) + e_i + k_t(t) + w_i;

  assign a_o = temp;
  assign b_o = a_i;
  assign c_o = rotl(b_i, 30);
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/ars_sha_1.sv
// SHA-1 compression core: serial 16-word block load, 80 rounds over a
// rolling 16-word schedule window, then one edge to add the chaining value.
module ars_sha_1
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  din,
  input  logic         load,
  input  logic         start,
  input  logic [159:0] cv,
  input  logic         use_prev_cv,
  output logic         busy,
  output logic         ready,
  output logic [159:0] cv_next,
  output logic [31:0]  w
);

  state_t       state_q, state_d;
  logic [6:0]   t_q, t_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d;
  logic [31:0]  a_n, b_n, c_n, d_n, e_n;
  logic [159:0] base_q, base_d;
  logic [159:0] cv_next_q, cv_next_d;
  logic         ready_q, ready_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  sched_tail;

  sha1_round u_round (
    .t   (t_q),
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .d_i (d_q),
    .e_i (e_q),
    .w_i (w_q[0]),
    .a_o (a_n),
    .b_o (b_n),
    .c_o (c_n),
    .d_o (d_n),
    .e_o (e_n)
  );

  // Window holds W[t..t+15]; the new tail is W[t+16].
  assign sched_tail = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    e_d       = e_q;
    base_d    = base_q;
    cv_next_d = cv_next_q;
    ready_d   = 1'b0;
    for (int i = 0; i < 16; i++) w_d[i] = w_q[i];

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = din;
        end else if (start) begin
          base_d  = use_prev_cv ? cv_next_q : cv;
          {a_d, b_d, c_d, d_d, e_d} = use_prev_cv ? cv_next_q : cv;
          t_d     = 7'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (t_q > LAST_T) begin
          cv_next_d = {base_q[159:128] + a_q, base_q[127:96] + b_q,
                       base_q[95:64] + c_q, base_q[63:32] + d_q,
                       base_q[31:0] + e_q};
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          a_d = a_n;
          b_d = b_n;
          c_d = c_n;
          d_d = d_n;
          e_d = e_n;
          t_d = t_q + 7'd1;
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = sched_tail;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      e_q       <= '0;
      base_q    <= '0;
      cv_next_q <= '0;
      ready_q   <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      e_q       <= e_d;
      base_q    <= base_d;
      cv_next_q <= cv_next_d;
      ready_q   <= ready_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

  assign busy    = (state_q == ST_ROUND);
  assign ready   = ready_q;
  assign cv_next = cv_next_q;
  assign w       = w_q[0];

endmodule

// File: tb/tb_ars_sha_1.sv
// Directed and randomized bench for ars_sha_1 against a full-array SHA-1
// compression model.
module tb_ars_sha_1;

  localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] ABC_H   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] TWO_H   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};

  logic         clk;
  logic         reset;
  logic [31:0]  din;
  logic         load;
  logic         start;
  logic [159:0] cv;
  logic         use_prev_cv;
  logic         busy;
  logic         ready;
  logic [159:0] cv_next;
  logic [31:0]  w;

  int tests;
  int fails;

  ars_sha_1 dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .load        (load),
    .start       (start),
    .cv          (cv),
    .use_prev_cv (use_prev_cv),
    .busy        (busy),
    .ready       (ready),
    .cv_next     (cv_next),
    .w           (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook compression: expand all 80 schedule words, then iterate.
  function automatic logic [159:0] sha1_model(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] wt [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int i = 0; i < 16; i++) wt[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) wt[i] = rl(wt[i-3] ^ wt[i-8] ^ wt[i-14] ^ wt[i-16], 1);
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rl(a, 5) + f + e + k + wt[i];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic load_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) begin
      load = 1'b1;
      din  = blk[511 - 32*i -: 32];
      @(negedge clk);
    end
    load = 1'b0;
    din  = '0;
  endtask

  // Starts a compression from a negedge, scrambles cv/use_prev_cv once busy,
  // optionally injects start+load pulses, and checks timing and result.
  task automatic run_block(input logic [159:0] cv_in, input logic use_prev,
                           input logic disturb, input logic [159:0] expv, input string tag);
    int cnt;
    int rdy;
    cv          = cv_in;
    use_prev_cv = use_prev;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    cv          = {$urandom, $urandom, $urandom, $urandom, $urandom};
    use_prev_cv = ~use_prev;
    cnt = 0;
    rdy = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (ready === 1'b1) rdy++;
      if (disturb && (cnt == 5 || cnt == 40 || cnt == 80)) begin
        start = 1'b1;
        load  = 1'b1;
        din   = $urandom;
      end else begin
        start = 1'b0;
        load  = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    load  = 1'b0;
    chk({tag, ".busy_cycles"}, 160'(cnt), 160'd81);
    chk({tag, ".ready_early"}, 160'(rdy), 160'd0);
    chk({tag, ".ready_pulse"}, 160'(ready), 160'd1);
    chk({tag, ".cv_next"}, cv_next, expv);
    @(negedge clk);
    chk({tag, ".ready_drop"}, 160'(ready), 160'd0);
    chk({tag, ".busy_idle"}, 160'(busy), 160'd0);
    $display("[TB] %s cv_next=%h", tag, cv_next);
  endtask

  initial begin
    logic [159:0] prev_h;
    logic [159:0] mid_h;
    logic [159:0] base;
    logic [159:0] cv_rand;
    logic [511:0] blk;
    logic         up;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    din = '0; load = 1'b0; start = 1'b0; cv = '0; use_prev_cv = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 160'(busy), 160'd0);
    chk("reset.ready", 160'(ready), 160'd0);
    chk("reset.cv_next", cv_next, 160'd0);
    chk("reset.w", 160'(w), 160'd0);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset checked");

    load_block(ABC_BLK);
    chk("abc.w_head", 160'(w), 160'h61626380);
    run_block(IV, 1'b0, 1'b0, ABC_H, "abc");

    load_block(ABC_BLK);
    run_block(IV, 1'b0, 1'b1, ABC_H, "abc_busy_pulses");

    mid_h = sha1_model(IV, TWO_B1);
    load_block(TWO_B1);
    run_block(IV, 1'b0, 1'b0, mid_h, "two.blk1");
    load_block(TWO_B2);
    run_block({5{32'hdeadbeef}}, 1'b1, 1'b0, TWO_H, "two.blk2");

    // Abort at round 40 and check the asynchronous clear between edges.
    load_block(ABC_BLK);
    cv = IV; use_prev_cv = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort.busy_before", 160'(busy), 160'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort.busy", 160'(busy), 160'd0);
    chk("abort.ready", 160'(ready), 160'd0);
    chk("abort.cv_next", cv_next, 160'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.no_ready", 160'(ready), 160'd0);
    $display("[TB] abort at round 40 checked");
    load_block(ABC_BLK);
    run_block(IV, 1'b0, 1'b0, ABC_H, "abc_after_abort");

    prev_h = ABC_H;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
      cv_rand = {$urandom, $urandom, $urandom, $urandom, $urandom};
      up      = 1'($urandom_range(0, 1));
      base    = up ? prev_h : cv_rand;
      prev_h  = sha1_model(base, blk);
      load_block(blk);
      run_block(cv_rand, up, 1'(n % 2), prev_h, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
